cpu_acc_ctl: RTL and testbench

//  CPU bus access controller that sits directly upstream of the ready stretcher.
//  - Synchronises the asynchronous CPU strobe pce_ into the clk domain.
//  - Latches the address, write data and direction, then runs one request/ack handshake on the internal register bus.
//  - Returns read data and emits a one-cycle rdy pulse; that pulse is the stretcher's rdyin.

---
 rtl/cpu_acc_ctl_pkg.sv | 13 +
 rtl/cpu_acc_ctl_if.sv | 15 +
 rtl/cpu_acc_ctl_sync2.sv | 22 ++
 rtl/cpu_acc_ctl.sv | 136 +++++++++++++
 tb/tb_cpu_acc_ctl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_acc_ctl_pkg.sv
// Shared types and constants for the CPU bus access controller.
package cpu_acc_ctl_pkg;

  typedef enum logic [1:0] {
    CPU_ACC_IDLE = 2'd0,
    CPU_ACC_REQ  = 2'd1,
    CPU_ACC_DONE = 2'd2,
    CPU_ACC_HOLD = 2'd3
  } cpu_acc_state_t;

  localparam logic [31:0] CPU_ACC_TOVAL_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/cpu_acc_ctl_if.sv
// Internal register bus: level request, registered address/data, 1-cycle ack with read data.
interface cpu_acc_ctl_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          reqrd;
  logic          reqwr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdat;
  logic [DW-1:0] rdat;
  logic          ack;

  modport master (output reqrd, reqwr, addr, wdat, input rdat, ack);
  modport slave  (input reqrd, reqwr, addr, wdat, output rdat, ack);
endinterface

// File: rtl/cpu_acc_ctl_sync2.sv
// cpu_sync2: 2-flop synchroniser, async active-low reset, resets to 1 (strobe inactive).
module cpu_sync2 (
  input  logic clk,
  input  logic rst_,
  input  logic d,
  output logic q
);
  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;
endmodule

// File: rtl/cpu_acc_ctl.sv
// CPU bus access controller: syncs pce_, runs one request/ack on the internal bus, pulses rdy.
// Optional timeout abort (timer, TOVAL read data, sticky err) enabled by macro CPU_ACC_TIMEOUT_EN.
module cpu_acc_ctl
  import cpu_acc_ctl_pkg::*;
#(
  parameter int            AW    = 8,
  parameter int            DW    = 32,
  parameter int            TOW   = 8,
  parameter logic [TOW-1:0] TOMAX = 8'hFF,
  parameter logic [DW-1:0] TOVAL = CPU_ACC_TOVAL_DEF
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           pce_,
  input  logic           pwe_,
  input  logic [AW-1:0]  paddr,
  input  logic [DW-1:0]  pdi,
  output logic [DW-1:0]  pdo,
  output logic           rdy,
  output logic           err,
  cpu_acc_ctl_if.master  bus
);

  cpu_acc_state_t r_state;
  cpu_acc_state_t w_state_nxt;

  logic          w_ce_s;
  logic          r_ce_d;
  logic          w_start;
  logic          w_ack_hit;
  logic          w_to_hit;
  logic          r_reqrd;
  logic          r_reqwr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdat;
  logic [DW-1:0] r_pdo;
  logic          r_rdy;

  cpu_sync2 u_sync_ce (
    .clk  (clk),
    .rst_ (rst_),
    .d    (pce_),
    .q    (w_ce_s)
  );

  // Falling edge of the synchronised strobe against its registered copy.
  assign w_start   = r_ce_d & ~w_ce_s;
  assign w_ack_hit = (r_state == CPU_ACC_REQ) & bus.ack;

`ifdef CPU_ACC_TIMEOUT_EN
  logic [TOW-1:0] r_timer;
  logic           r_err;

  assign w_to_hit = (r_state == CPU_ACC_REQ) & ~bus.ack & (r_timer == TOMAX);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == CPU_ACC_IDLE && w_start) begin
        r_timer <= '0;
      end else if (r_state == CPU_ACC_REQ && r_timer != '1) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_to_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  logic w_unused_cfg;

  assign w_to_hit     = 1'b0;
  assign err          = 1'b0;
  assign w_unused_cfg = ^{TOMAX, TOVAL};
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= CPU_ACC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      CPU_ACC_IDLE: if (w_start)               w_state_nxt = CPU_ACC_REQ;
      CPU_ACC_REQ:  if (w_ack_hit || w_to_hit) w_state_nxt = CPU_ACC_DONE;
      CPU_ACC_DONE: w_state_nxt = w_ce_s ? CPU_ACC_IDLE : CPU_ACC_HOLD;
      CPU_ACC_HOLD: if (w_ce_s)                w_state_nxt = CPU_ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_ce_d  <= 1'b1;
      r_reqrd <= 1'b0;
      r_reqwr <= 1'b0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_pdo   <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_ce_d <= w_ce_s;
      r_rdy  <= 1'b0;
      if (r_state == CPU_ACC_IDLE && w_start) begin
        r_addr  <= paddr;
        r_wdat  <= pdi;
        r_reqrd <= pwe_;
        r_reqwr <= ~pwe_;
      end
      if (w_ack_hit || w_to_hit) begin
        r_reqrd <= 1'b0;
        r_reqwr <= 1'b0;
        r_rdy   <= 1'b1;
        // The still-high read request marks the direction of the access in flight.
        if (r_reqrd) begin
          r_pdo <= w_ack_hit ? bus.rdat : TOVAL;
        end
      end
    end
  end

  assign bus.reqrd = r_reqrd;
  assign bus.reqwr = r_reqwr;
  assign bus.addr  = r_addr;
  assign bus.wdat  = r_wdat;
  assign pdo       = r_pdo;
  assign rdy       = r_rdy;

endmodule

// File: tb/tb_cpu_acc_ctl.sv
// Directed self-checking bench for cpu_acc_ctl; timeout cases depend on CPU_ACC_TIMEOUT_EN.
module tb_cpu_acc_ctl;
  import cpu_acc_ctl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_;
  logic        pce_;
  logic        pwe_;
  logic [7:0]  paddr;
  logic [31:0] pdi;
  logic [31:0] pdo;
  logic        rdy;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;

  cpu_acc_ctl_if #(.AW(8), .DW(32)) bus ();

  cpu_acc_ctl #(
    .AW    (8),
    .DW    (32),
    .TOW   (8),
    .TOMAX (8'hFF),
    .TOVAL (32'hDEAD_BEEF)
  ) dut (
    .clk   (clk),
    .rst_  (rst_),
    .pce_  (pce_),
    .pwe_  (pwe_),
    .paddr (paddr),
    .pdi   (pdi),
    .pdo   (pdo),
    .rdy   (rdy),
    .err   (err),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.reqrd || bus.reqwr) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic release_ce();
    pce_ = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int lat;
    int hi;
    int n_req;
    int n_rdy;

    rst_ = 1'b1; pce_ = 1'b1; pwe_ = 1'b1; paddr = '0; pdi = '0;
    bus.ack = 1'b0; bus.rdat = '0;
    #2 rst_ = 1'b0;
    repeat (3) tick();
    chk("rst_pdo",   pdo,         32'h0);
    chk("rst_rdy",   rdy,         32'h0);
    chk("rst_reqrd", bus.reqrd,   32'h0);
    chk("rst_reqwr", bus.reqwr,   32'h0);
    chk("rst_addr",  bus.addr,    32'h0);
    chk("rst_wdat",  bus.wdat,    32'h0);
    chk("rst_err",   err,         32'h0);
    chk("rst_state", dut.r_state, CPU_ACC_IDLE);
    rst_ = 1'b1;
    repeat (2) tick();

    // Stray ack in IDLE
    bus.ack = 1'b1; bus.rdat = 32'hFFFF_FFFF;
    tick();
    bus.ack = 1'b0; bus.rdat = '0;
    tick();
    chk("idle_ack_rdy", rdy, 32'h0);
    chk("idle_ack_pdo", pdo, 32'h0);

    // 1: read
    pce_ = 1'b0; pwe_ = 1'b1; paddr = 8'h12; pdi = '0;
    wait_req(lat);
    chk("rd_lat",   lat,       32'd3);
    chk("rd_reqwr", bus.reqwr, 32'h0);
    chk("rd_addr",  bus.addr,  32'h12);
    repeat (3) tick();
    chk("rd_hold",  bus.reqrd, 32'h1);
    bus.ack = 1'b1; bus.rdat = 32'hA5A5_0001;
    tick();
    bus.ack = 1'b0; bus.rdat = '0;
    chk("rd_rdy",   rdy,         32'h1);
    chk("rd_pdo",   pdo,         32'hA5A5_0001);
    chk("rd_drop",  bus.reqrd,   32'h0);
    chk("rd_done",  dut.r_state, CPU_ACC_DONE);
    tick();
    chk("rd_rdy1",  rdy,         32'h0);
    chk("rd_pdo1",  pdo,         32'hA5A5_0001);
    chk("rd_hold_st", dut.r_state, CPU_ACC_HOLD);
    release_ce();
    chk("rd_idle",  dut.r_state, CPU_ACC_IDLE);

    // 2: write
    pce_ = 1'b0; pwe_ = 1'b0; paddr = 8'h34; pdi = 32'h1234_5678;
    wait_req(lat);
    chk("wr_lat",   lat,       32'd3);
    chk("wr_reqrd", bus.reqrd, 32'h0);
    chk("wr_wdat",  bus.wdat,  32'h1234_5678);
    chk("wr_addr",  bus.addr,  32'h34);
    tick();
    chk("wr_hold",  bus.reqwr, 32'h1);
    bus.ack = 1'b1; bus.rdat = 32'h5555_5555;
    tick();
    bus.ack = 1'b0; bus.rdat = '0;
    chk("wr_rdy",   rdy,       32'h1);
    chk("wr_pdo",   pdo,       32'hA5A5_0001);
    chk("wr_drop",  bus.reqwr, 32'h0);
    tick();
    chk("wr_rdy1",  rdy,       32'h0);
    release_ce();

    // 5: short chip enable
    pce_ = 1'b0; pwe_ = 1'b1; paddr = 8'h56; pdi = '0;
    wait_req(lat);
    chk("sh_lat", lat, 32'd3);
    pce_ = 1'b1;
    repeat (5) tick();
    chk("sh_hold", bus.reqrd, 32'h1);
    bus.ack = 1'b1; bus.rdat = 32'hC0DE_0005;
    tick();
    bus.ack = 1'b0; bus.rdat = '0;
    chk("sh_rdy",  rdy, 32'h1);
    chk("sh_pdo",  pdo, 32'hC0DE_0005);
    tick();
    chk("sh_idle", dut.r_state, CPU_ACC_IDLE);
    chk("sh_rdy1", rdy, 32'h0);
    repeat (3) tick();

    // 6: held strobe
    pce_ = 1'b0; pwe_ = 1'b1; paddr = 8'h78;
    wait_req(lat);
    chk("hd_lat", lat, 32'd3);
    bus.ack = 1'b1; bus.rdat = 32'h0000_0006;
    tick();
    bus.ack = 1'b0; bus.rdat = '0;
    chk("hd_rdy", rdy, 32'h1);
    n_req = 0; n_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.reqrd || bus.reqwr) n_req++;
      if (rdy) n_rdy++;
    end
    chk("hd_nreq",  n_req,       32'd0);
    chk("hd_nrdy",  n_rdy,       32'd0);
    chk("hd_state", dut.r_state, CPU_ACC_HOLD);
    chk("hd_pdo",   pdo,         32'h0000_0006);
    release_ce();

`ifdef CPU_ACC_TIMEOUT_EN
    // 4: ack lands on the timeout cycle
    pce_ = 1'b0; pwe_ = 1'b1; paddr = 8'h9A;
    wait_req(lat);
    repeat (255) tick();
    chk("ta_hold", bus.reqrd, 32'h1);
    bus.ack = 1'b1; bus.rdat = 32'h0BAD_0004;
    tick();
    bus.ack = 1'b0; bus.rdat = '0;
    chk("ta_drop", bus.reqrd, 32'h0);
    chk("ta_rdy",  rdy,       32'h1);
    chk("ta_pdo",  pdo,       32'h0BAD_0004);
    chk("ta_err",  err,       32'h0);
    release_ce();

    // 3: timeout, no ack
    pce_ = 1'b0; pwe_ = 1'b1; paddr = 8'hBC;
    wait_req(lat);
    hi = (lat != 0) ? 1 : 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!bus.reqrd) break;
      hi++;
    end
    chk("to_cycles", hi,  32'd256);
    chk("to_rdy",    rdy, 32'h1);
    chk("to_pdo",    pdo, 32'hDEAD_BEEF);
    chk("to_err",    err, 32'h1);
    release_ce();
    chk("to_err_sticky", err, 32'h1);
`else
    // No timeout: request waits indefinitely
    pce_ = 1'b0; pwe_ = 1'b1; paddr = 8'h9A;
    wait_req(lat);
    hi = 0;
    repeat (300) tick();
    chk("nt_hold", bus.reqrd, 32'h1);
    chk("nt_err",  err,       32'h0);
    bus.ack = 1'b1; bus.rdat = 32'h0BAD_0004;
    tick();
    bus.ack = 1'b0; bus.rdat = '0;
    chk("nt_rdy",  rdy, 32'h1);
    chk("nt_pdo",  pdo, 32'h0BAD_0004);
    release_ce();
`endif

    // 6a: reset during REQ
    pce_ = 1'b0; pwe_ = 1'b1; paddr = 8'hDE;
    wait_req(lat);
    chk("rr_req", bus.reqrd, 32'h1);
    rst_ = 1'b0;
    #1;
    chk("rr_reqrd", bus.reqrd,   32'h0);
    chk("rr_pdo",   pdo,         32'h0);
    chk("rr_addr",  bus.addr,    32'h0);
    chk("rr_err",   err,         32'h0);
    chk("rr_state", dut.r_state, CPU_ACC_IDLE);
    pce_ = 1'b1;
    repeat (2) tick();
    rst_ = 1'b1;
    repeat (3) tick();
    chk("rr_quiet", bus.reqrd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
